// File: rtl/muldiv_pkg.sv
// Shared types for the multicycle MIPS multiply/divide unit.
// The main control FSM imports muldiv_op_t to drive the op select.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } muldiv_op_t;

  localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV unit owning HI/LO.
// MULT uses radix-2 Booth over a 2*WIDTH+1 accumulator.
// DIV uses restoring division on operand magnitudes, then sign-fixes the results.
// HI/LO only change on the final iteration, so MFHI/MFLO never see partial results.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITER
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  muldiv_state_t    state_r;
  logic [CW-1:0]    cnt_r;
  logic [2*WIDTH:0] acc_r;       // {P, multiplier/low product, q_-1}
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH:0]   rem_r;       // partial remainder
  logic [WIDTH-1:0] quo_r;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_r;      // divisor magnitude
  logic             a_neg_r;
  logic             q_neg_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             div_zero_r;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [2*WIDTH:0] booth_next_s;
  logic [WIDTH+1:0] div_shift_s;
  logic [WIDTH:0]   rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand magnitudes for the divider, captured on the accepting edge.
  always_comb begin
    a_mag_s = oper_A;
    b_mag_s = oper_B;
    if (oper_A[WIDTH-1]) begin
      a_mag_s = -oper_A;
    end else begin
      a_mag_s = oper_A;
    end
    if (oper_B[WIDTH-1]) begin
      b_mag_s = -oper_B;
    end else begin
      b_mag_s = oper_B;
    end
  end

  // Booth step: add/subtract the multiplicand in WIDTH+1 bits (so the most
  // negative multiplicand cannot overflow), then arithmetic shift right by one.
  always_comb begin
    booth_sum_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]};
    case (acc_r[1:0])
      2'b01:   booth_sum_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]}
                             + {mcand_r[WIDTH-1], mcand_r};
      2'b10:   booth_sum_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]}
                             - {mcand_r[WIDTH-1], mcand_r};
      default: booth_sum_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]};
    endcase
    booth_next_s = {booth_sum_s, acc_r[WIDTH:1]};
  end

  // Restoring step: shift in the next dividend bit, subtract when it fits,
  // and produce the sign-fixed results used on the final iteration.
  always_comb begin
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    rem_next_s  = div_shift_s[WIDTH:0];
    quo_next_s  = {quo_r[WIDTH-2:0], 1'b0};
    if (div_shift_s >= {2'b00, dvsr_r}) begin
      rem_next_s = div_shift_s[WIDTH:0] - {1'b0, dvsr_r};
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = div_shift_s[WIDTH:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end
    // Quotient truncates toward zero; remainder follows the dividend sign.
    // The most negative dividend over -1 wraps back to itself without a flag.
    if (q_neg_r) begin
      quo_fix_s = -quo_next_s;
    end else begin
      quo_fix_s = quo_next_s;
    end
    if (a_neg_r) begin
      rem_fix_s = -rem_next_s[WIDTH-1:0];
    end else begin
      rem_fix_s = rem_next_s[WIDTH-1:0];
    end
  end

  // Sequencer state, iteration datapath and HI/LO ownership.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      acc_r      <= '0;
      mcand_r    <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvsr_r     <= '0;
      a_neg_r    <= 1'b0;
      q_neg_r    <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r      <= '0;
            div_zero_r <= 1'b0;
            mcand_r    <= oper_A;
            acc_r      <= {{WIDTH{1'b0}}, oper_B, 1'b0};
            rem_r      <= '0;
            quo_r      <= a_mag_s;
            dvsr_r     <= b_mag_s;
            a_neg_r    <= oper_A[WIDTH-1];
            q_neg_r    <= oper_A[WIDTH-1] ^ oper_B[WIDTH-1];
            if (muldiv_op_t'(op) == OP_DIV) begin
              if (oper_B == '0) begin
                // Divide by zero: report immediately, HI/LO untouched.
                div_zero_r <= 1'b1;
                state_r    <= DONE;
              end else begin
                state_r <= DIV;
              end
            end else begin
              state_r <= MULT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MULT: begin
          acc_r <= booth_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_STEP) begin
            hi_r    <= booth_next_s[2*WIDTH:WIDTH+1];
            lo_r    <= booth_next_s[WIDTH:1];
            state_r <= DONE;
          end else begin
            state_r <= MULT;
          end
        end
        DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_STEP) begin
            hi_r    <= rem_fix_s;
            lo_r    <= quo_fix_s;
            state_r <= DONE;
          end else begin
            state_r <= DIV;
          end
        end
        DONE: begin
          // start is ignored here; it is not queued.
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_r != IDLE);
  assign done     = (state_r == DONE);
  assign div_zero = div_zero_r;
  assign HI       = hi_r;
  assign LO       = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  logic        Clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] oper_A;
  logic [31:0] oper_B;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op),
    .oper_A(oper_A), .oper_B(oper_B), .busy(busy), .done(done),
    .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed 64-bit product.
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Reference: {remainder, quotient}, both low 32 bits of exact 64-bit math.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one operation from IDLE; returns cycles from accept to done (-1 on timeout)
  // and whether busy stayed high up to done.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    @(negedge Clk);
    start = 1'b1; op = o; oper_A = a; oper_B = b;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0; oper_A = $urandom; oper_B = $urandom;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; oper_A = 32'h0; oper_B = 32'h0;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %0b want 0", div_zero); end
    checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h_%h want 0_0", HI, LO); end
    model_hi = 32'h0; model_lo = 32'h0;
  endtask

  task automatic test_mult_directed();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] te [4];
    int lat; bit bok;
    ta = '{32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'h00000002};
    tb = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00000003};
    te = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h00000000_00000001, 64'h00000000_00000006};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, ta[i], tb[i], lat, bok);
      checks++; if (lat !== 32) begin errors++; $display("FAIL mult_latency[%0d] got %0d want 32", i, lat); end
      checks++; if (!bok) begin errors++; $display("FAIL mult_busy[%0d] got low want high", i); end
      checks++; if ({HI, LO} !== te[i]) begin errors++; $display("FAIL mult_result[%0d] got %h_%h want %h", i, HI, LO, te[i]); end
      @(negedge Clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mult_end[%0d] busy/done got %b want 00", i, {busy, done}); end
      model_hi = te[i][63:32]; model_lo = te[i][31:0];
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [63:0] te [5];
    int lat; bit bok;
    ta = '{32'hFFFFFFF9, 32'h00000064, 32'h80000000, 32'h00000007, 32'h00002211};
    tb = '{32'h00000002, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000100};
    te = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000002_FFFFFFF2, 64'h00000000_80000000,
           64'h00000001_FFFFFFFD, 64'h00000011_00000022};
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, ta[i], tb[i], lat, bok);
      checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency[%0d] got %0d want 32", i, lat); end
      checks++; if ({HI, LO} !== te[i]) begin errors++; $display("FAIL div_result[%0d] got %h_%h want %h", i, HI, LO, te[i]); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_flag[%0d] got %0b want 0", i, div_zero); end
      model_hi = te[i][63:32]; model_lo = te[i][31:0];
    end
    @(negedge Clk);
  endtask

  // Runs right after the directed DIV that left HI=0x11, LO=0x22.
  task automatic test_div_zero();
    int lat; bit bok;
    do_op(1'b1, 32'h00000005, 32'h00000000, lat, bok);
    checks++; if (lat !== 0) begin errors++; $display("FAIL divzero_latency got %0d want 0", lat); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divzero_flag got %0b want 1", div_zero); end
    checks++; if ({HI, LO} !== {32'h11, 32'h22}) begin errors++; $display("FAIL divzero_hilo got %h_%h want 00000011_00000022", HI, LO); end
    @(negedge Clk);
    checks++; if ({busy, done, div_zero} !== 3'b001) begin errors++; $display("FAIL divzero_idle busy/done/flag got %b want 001", {busy, done, div_zero}); end
    do_op(1'b0, 32'h2, 32'h3, lat, bok);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divzero_clear got %0b want 0", div_zero); end
    checks++; if (LO !== 32'h6) begin errors++; $display("FAIL divzero_next_mult got %h want 00000006", LO); end
    model_hi = 32'h0; model_lo = 32'h6;
    @(negedge Clk);
  endtask

  task automatic test_ignore_start();
    logic [63:0] exp;
    exp = ref_mult(32'h12345678, 32'hFEDCBA98);
    @(negedge Clk);
    start = 1'b1; op = 1'b0; oper_A = 32'h12345678; oper_B = 32'hFEDCBA98;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    start = 1'b1; op = 1'b1; oper_A = 32'h00000009; oper_B = 32'h00000003;
    @(negedge Clk);
    start = 1'b0;
    repeat (22) @(negedge Clk);
    checks++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL ignore_done busy/done got %b want 11", {busy, done}); end
    checks++; if ({HI, LO} !== exp) begin errors++; $display("FAIL ignore_result got %h_%h want %h", HI, LO, exp); end
    start = 1'b1; op = 1'b0; oper_A = 32'h5; oper_B = 32'h5;
    @(negedge Clk);
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ignore_busy_fall got %b want 00", {busy, done}); end
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued busy got %0b want 0", busy); end
    checks++; if ({HI, LO} !== exp) begin errors++; $display("FAIL ignore_hold got %h_%h want %h", HI, LO, exp); end
    model_hi = exp[63:32]; model_lo = exp[31:0];
  endtask

  task automatic test_reset_mid();
    bit seen;
    int lat; bit bok;
    @(negedge Clk);
    start = 1'b1; op = 1'b1; oper_A = 32'h7FFFFFFF; oper_B = 32'h00000003;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (14) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset_ctrl got %b want 00", {busy, done}); end
    checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL midreset_hilo got %h_%h want 0_0", HI, LO); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_done got activity want none"); end
    do_op(1'b0, 32'h3, 32'h4, lat, bok);
    checks++; if ({HI, LO} !== 64'hC) begin errors++; $display("FAIL midreset_next got %h_%h want 0_0000000c", HI, LO); end
    model_hi = 32'h0; model_lo = 32'hC;
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat, want_lat; bit bok, want_dz;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h80000000;
        3: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (o && b == 32'h0) begin
        exp = {model_hi, model_lo}; want_lat = 0; want_dz = 1'b1;
      end else if (o) begin
        exp = ref_div(a, b); want_lat = 32; want_dz = 1'b0;
      end else begin
        exp = ref_mult(a, b); want_lat = 32; want_dz = 1'b0;
      end
      do_op(o, a, b, lat, bok);
      checks++; if (lat !== want_lat) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, want_lat); end
      checks++; if ({HI, LO} !== exp) begin errors++; $display("FAIL rand_result[%0d] op=%0b a=%h b=%h got %h_%h want %h", i, o, a, b, HI, LO, exp); end
      checks++; if (div_zero !== want_dz) begin errors++; $display("FAIL rand_divzero[%0d] got %0b want %0b", i, div_zero, want_dz); end
      model_hi = exp[63:32]; model_lo = exp[31:0];
    end
    @(negedge Clk);
  endtask

  // Second accept lands on the first IDLE edge after done (E34).
  task automatic test_back_to_back();
    int lat; bit bok;
    do_op(1'b0, 32'hFFFFFFF0, 32'h00000010, lat, bok);
    do_op(1'b1, 32'h0000007B, 32'h0000000A, lat, bok);
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency got %0d want 32", lat); end
    checks++; if ({HI, LO} !== {32'h3, 32'hC}) begin errors++; $display("FAIL b2b_result got %h_%h want 00000003_0000000c", HI, LO); end
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
